// File: rtl/memarb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package memarb_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CONFLICT_W = 16;
  localparam int unsigned STARVE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_e;

  // Increment that sticks at all-ones.
  function automatic logic [CONFLICT_W-1:0] sat_inc_conflict(input logic [CONFLICT_W-1:0] v);
    return (&v) ? v : v + CONFLICT_W'(1);
  endfunction

endpackage

// File: rtl/m_memarb_starve.sv
// Fetch starvation counter: forces a fetch grant after STARVE_MAX consecutive denials.
// Instantiated by m_memarb only when ARB_STARVE_EN is defined.
module m_memarb_starve
  import memarb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic w_i_req,
  input  logic w_i_gnt,
  output logic w_force_i
);

  logic [STARVE_W-1:0] r_starve;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_starve <= '0;
    end else if (!w_i_req || w_i_gnt) begin
      r_starve <= '0;
    end else if (r_starve != '1) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign w_force_i = (r_starve >= STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/m_memarb.sv
// Arbiter sharing one registered-read memory between fetch and data ports.
// Optional fetch anti-starvation is enabled by defining ARB_STARVE_EN.
module m_memarb
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_i_req,
  input  logic [ADDR_W-1:0]     w_i_addr,
  output logic                  w_i_gnt,
  output logic                  r_i_valid,
  output logic [DATA_W-1:0]     w_i_rdata,
  input  logic                  w_d_req,
  input  logic                  w_d_we,
  input  logic [ADDR_W-1:0]     w_d_addr,
  input  logic [DATA_W-1:0]     w_d_din,
  output logic                  w_d_gnt,
  output logic                  r_d_valid,
  output logic [DATA_W-1:0]     w_d_rdata,
  output logic [ADDR_W-1:0]     w_m_addr,
  output logic                  w_m_we,
  output logic [DATA_W-1:0]     w_m_din,
  input  logic [DATA_W-1:0]     w_m_dout,
  output logic [CONFLICT_W-1:0] r_conflict
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("m_memarb: STARVE_MAX must be in 1..15");
  end

  own_e              r_own;
  own_e              w_own_nxt;
  logic [DATA_W-1:0] r_i_hold;
  logic [DATA_W-1:0] r_d_hold;
  logic              w_force_i;

`ifdef ARB_STARVE_EN
  m_memarb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_i_req   (w_i_req),
    .w_i_gnt   (w_i_gnt),
    .w_force_i (w_force_i)
  );
`else
  assign w_force_i = 1'b0;
`endif

  // Grant mux: data wins unless fetch is being forced; nothing is granted in reset.
  always_comb begin
    w_i_gnt   = 1'b0;
    w_d_gnt   = 1'b0;
    w_own_nxt = OWN_NONE;
    if (!w_rst) begin
      w_i_gnt = w_i_req & (w_force_i | ~w_d_req);
      w_d_gnt = w_d_req & ~w_i_gnt;
    end
    if (w_i_gnt) begin
      w_own_nxt = OWN_I;
    end else if (w_d_gnt && !w_d_we) begin
      w_own_nxt = OWN_D;
    end
  end

  assign w_m_addr = w_d_gnt ? w_d_addr : (w_i_gnt ? w_i_addr : '0);
  assign w_m_we   = w_d_gnt & w_d_we;
  assign w_m_din  = w_d_din;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_own      <= OWN_NONE;
      r_i_hold   <= '0;
      r_d_hold   <= '0;
      r_conflict <= '0;
    end else begin
      r_own <= w_own_nxt;
      if (r_i_valid) begin
        r_i_hold <= w_m_dout;
      end
      if (r_d_valid) begin
        r_d_hold <= w_m_dout;
      end
      if (w_i_req && w_d_req) begin
        r_conflict <= sat_inc_conflict(r_conflict);
      end
    end
  end

  // Read data returns one cycle after the grant, to whichever port owned it.
  assign r_i_valid = (r_own == OWN_I);
  assign r_d_valid = (r_own == OWN_D);
  assign w_i_rdata = r_i_valid ? w_m_dout : r_i_hold;
  assign w_d_rdata = r_d_valid ? w_m_dout : r_d_hold;

endmodule

// File: tb/tb_m_memarb.sv
// Directed self-checking bench for m_memarb with a behavioural 4Kx32 registered-read memory.
module tb_m_memarb;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          w_clk;
  logic          w_rst;
  logic          w_i_req;
  logic [AW-1:0] w_i_addr;
  logic          w_i_gnt;
  logic          r_i_valid;
  logic [DW-1:0] w_i_rdata;
  logic          w_d_req;
  logic          w_d_we;
  logic [AW-1:0] w_d_addr;
  logic [DW-1:0] w_d_din;
  logic          w_d_gnt;
  logic          r_d_valid;
  logic [DW-1:0] w_d_rdata;
  logic [AW-1:0] w_m_addr;
  logic          w_m_we;
  logic [DW-1:0] w_m_din;
  logic [DW-1:0] w_m_dout;
  logic [15:0]   r_conflict;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_chk;
  int n_pass;

  m_memarb #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .w_i_req    (w_i_req),
    .w_i_addr   (w_i_addr),
    .w_i_gnt    (w_i_gnt),
    .r_i_valid  (r_i_valid),
    .w_i_rdata  (w_i_rdata),
    .w_d_req    (w_d_req),
    .w_d_we     (w_d_we),
    .w_d_addr   (w_d_addr),
    .w_d_din    (w_d_din),
    .w_d_gnt    (w_d_gnt),
    .r_d_valid  (r_d_valid),
    .w_d_rdata  (w_d_rdata),
    .w_m_addr   (w_m_addr),
    .w_m_we     (w_m_we),
    .w_m_din    (w_m_din),
    .w_m_dout   (w_m_dout),
    .r_conflict (r_conflict)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Registered-read single-port RAM.
  always @(posedge w_clk) begin
    if (w_m_we) mem[w_m_addr] <= w_m_din;
    w_m_dout <= mem[w_m_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_i_req  = 1'b0;
    w_i_addr = '0;
    w_d_req  = 1'b0;
    w_d_we   = 1'b0;
    w_d_addr = '0;
    w_d_din  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    w_m_dout = '0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = DW'(k + 100);

    // Reset with both ports requesting: no grants, no write enable.
    w_rst    = 1'b1;
    w_i_req  = 1'b1;
    w_i_addr = AW'(1);
    w_d_req  = 1'b1;
    w_d_we   = 1'b1;
    w_d_addr = AW'(2);
    w_d_din  = 32'h1234_5678;
    #1;
    check("rst_i_gnt", 32'(w_i_gnt), 32'd0);
    check("rst_d_gnt", 32'(w_d_gnt), 32'd0);
    check("rst_m_we", 32'(w_m_we), 32'd0);
    tick();
    tick();
    idle_inputs();
    w_rst = 1'b0;
    #1;
    check("rst_i_valid", 32'(r_i_valid), 32'd0);
    check("rst_d_valid", 32'(r_d_valid), 32'd0);
    check("rst_i_rdata", w_i_rdata, 32'd0);
    check("rst_d_rdata", w_d_rdata, 32'd0);
    check("rst_conflict", 32'(r_conflict), 32'd0);
    tick();

    // Fetch-only stream 0,1,2: data k+100 one cycle after each grant.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        w_i_req  = 1'b1;
        w_i_addr = AW'(k);
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 3) begin
        check($sformatf("fetch_gnt%0d", k), 32'(w_i_gnt), 32'd1);
        check($sformatf("fetch_maddr%0d", k), 32'(w_m_addr), 32'(k));
      end else begin
        check("idle_maddr", 32'(w_m_addr), 32'd0);
        check("idle_mwe", 32'(w_m_we), 32'd0);
      end
      if (k > 0) begin
        check($sformatf("fetch_valid%0d", k - 1), 32'(r_i_valid), 32'd1);
        check($sformatf("fetch_data%0d", k - 1), w_i_rdata, 32'(k - 1 + 100));
      end else begin
        check("fetch_valid_first", 32'(r_i_valid), 32'd0);
      end
      tick();
    end
    check("idle_no_valid", 32'(r_i_valid), 32'd0);
    check("fetch_hold", w_i_rdata, 32'd102);

    // Data read of address 3.
    w_d_req  = 1'b1;
    w_d_addr = AW'(3);
    #1;
    check("dread_gnt", 32'(w_d_gnt), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("dread_valid", 32'(r_d_valid), 32'd1);
    check("dread_data", w_d_rdata, 32'd103);
    tick();
    check("dread_hold", w_d_rdata, 32'd103);

    // Write 5 then fetch 5 back to back.
    w_d_req  = 1'b1;
    w_d_we   = 1'b1;
    w_d_addr = AW'(5);
    w_d_din  = 32'hDEAD_BEEF;
    #1;
    check("wr_mwe", 32'(w_m_we), 32'd1);
    check("wr_maddr", 32'(w_m_addr), 32'd5);
    check("wr_mdin", w_m_din, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    w_i_req  = 1'b1;
    w_i_addr = AW'(5);
    #1;
    check("wr_mwe_next", 32'(w_m_we), 32'd0);
    check("wr_fetch_gnt", 32'(w_i_gnt), 32'd1);
    check("wr_no_dvalid", 32'(r_d_valid), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("wr_fetch_valid", 32'(r_i_valid), 32'd1);
    check("wr_fetch_data", w_i_rdata, 32'hDEAD_BEEF);
    tick();

    // Contention for 6 cycles.
    for (int k = 1; k <= 6; k++) begin
      w_i_req  = 1'b1;
      w_i_addr = AW'(7);
      w_d_req  = 1'b1;
      w_d_we   = 1'b0;
      w_d_addr = AW'(8);
      #1;
`ifdef ARB_STARVE_EN
      check($sformatf("starve_cnt%0d", k), 32'(dut.u_starve.r_starve), (k == 6) ? 32'd0 : 32'(k - 1));
      check($sformatf("cont_i_gnt%0d", k), 32'(w_i_gnt), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("cont_d_gnt%0d", k), 32'(w_d_gnt), (k == 5) ? 32'd0 : 32'd1);
`else
      check($sformatf("cont_i_gnt%0d", k), 32'(w_i_gnt), 32'd0);
      check($sformatf("cont_d_gnt%0d", k), 32'(w_d_gnt), 32'd1);
`endif
      tick();
    end
    idle_inputs();
    #1;
    check("cont_count", 32'(r_conflict), 32'd6);
    tick();

    // Read granted, then reset in the following cycle.
    w_d_req  = 1'b1;
    w_d_addr = AW'(3);
    #1;
    check("rstmid_gnt", 32'(w_d_gnt), 32'd1);
    tick();
    idle_inputs();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0;
    #1;
    check("rstmid_dvalid", 32'(r_d_valid), 32'd0);
    check("rstmid_conflict", 32'(r_conflict), 32'd0);
    check("rstmid_i_rdata", w_i_rdata, 32'd0);
    check("rstmid_d_rdata", w_d_rdata, 32'd0);
    tick();

    // Saturation of the contention counter from FFFE.
    force dut.r_conflict = 16'hFFFE;
    #1;
    release dut.r_conflict;
    w_i_req  = 1'b1;
    w_i_addr = AW'(1);
    w_d_req  = 1'b1;
    w_d_addr = AW'(2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sat%0d", k), 32'(r_conflict), 32'h0000_FFFF);
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
